// File: rtl/add16_result_stage.sv
`default_nettype none
// ============================================================================
//  Module      : add16_result_stage
//  Description : Registered result stage behind the 16-bit ripple adder.
//                Captures the adder sum and carry, and computes the Z/N/C/V
//                flags as each beat is captured. Results go to the ALU
//                writeback over a valid/ready interface. A two-entry skid
//                buffer gives one beat per clock while keeping in_ready a
//                registered output.
//  Options     : ALU_SAT_EN - when defined, a result that overflows is
//                saturated to the largest positive or most negative value.
//                When undefined, the result is the sum unchanged (wraps).
//  Revision    : 1.0 - initial release
// ============================================================================
module add16_result_stage #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum,
    input  logic             c_out,
    input  logic             a_msb,
    input  logic             b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic [CNT_W-1:0] res_cnt
);

    // Buffer occupancy: EMPTY, ONE (output register full), or TWO (output
    // register and skid register both full).
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    // A captured beat is stored as {v, c, n, z, result}.
    localparam int PW = WIDTH + 4;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef ALU_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             in_ready_q;
    logic [PW-1:0]    out_q;
    logic [PW-1:0]    skid_q;
    logic [CNT_W-1:0] res_cnt_q;

    logic             accept_w;
    logic             deliver_w;
    logic             ld_out_in_w;
    logic             ld_out_skid_w;
    logic             ld_skid_w;

    logic             cap_v_w;
    logic [WIDTH-1:0] cap_res_w;
    logic [PW-1:0]    cap_w;

    // Handshake qualifiers; in_ready is the registered copy, so accepts are
    // never possible while both entries are occupied.
    assign accept_w  = in_valid && in_ready_q;
    assign deliver_w = out_valid && out_ready;

    // Build the beat to be captured: overflow flag, optional saturation,
    // then Z/N from the final result so they agree with what is delivered.
    always_comb begin
        cap_v_w   = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
        cap_res_w = sum;
`ifdef ALU_SAT_EN
        if (cap_v_w) begin
            cap_res_w = a_msb ? SAT_NEG : SAT_POS;
        end
`endif
        cap_w = {cap_v_w, c_out, cap_res_w[WIDTH-1], (cap_res_w == '0), cap_res_w};
    end

    // State register, with the registered in_ready following the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != S_TWO);
        end
    end

    // Next-state logic for buffer occupancy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: begin
                if (accept_w) begin
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (accept_w && !deliver_w) begin
                    state_d = S_TWO;
                end else if (!accept_w && deliver_w) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (deliver_w) begin
                    state_d = S_ONE;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    // Output decode: valid flag and datapath load enables for each state.
    always_comb begin
        out_valid     = (state_q != S_EMPTY);
        ld_out_in_w   = 1'b0;
        ld_out_skid_w = 1'b0;
        ld_skid_w     = 1'b0;
        case (state_q)
            S_EMPTY: begin
                ld_out_in_w = accept_w;
            end
            S_ONE: begin
                // A new beat either replaces the delivered one or parks in skid.
                ld_out_in_w = accept_w && deliver_w;
                ld_skid_w   = accept_w && !deliver_w;
            end
            S_TWO: begin
                ld_out_skid_w = deliver_w;
            end
            default: begin
                ld_out_in_w = 1'b0;
            end
        endcase
    end

    // Output and skid registers; contents hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (ld_out_in_w) begin
                out_q <= cap_w;
            end else if (ld_out_skid_w) begin
                out_q <= skid_q;
            end
            if (ld_skid_w) begin
                skid_q <= cap_w;
            end
        end
    end

    // Delivered-result counter, wrapping naturally at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_cnt_q <= '0;
        end else if (deliver_w) begin
            res_cnt_q <= res_cnt_q + CNT_ONE;
        end
    end

    assign in_ready = in_ready_q;
    assign result   = out_q[WIDTH-1:0];
    assign flag_z   = out_q[WIDTH];
    assign flag_n   = out_q[WIDTH+1];
    assign flag_c   = out_q[WIDTH+2];
    assign flag_v   = out_q[WIDTH+3];
    assign res_cnt  = res_cnt_q;

endmodule
`default_nettype wire
